pipeline_stall_sequencer: RTL

Sequences the MIPS pipeline front end from the hazard detector's decisions. Inputs are the data-hazard stall flag and the control-transfer request with its wait count. The block generates the PC enable, the IF/ID enable, the ID/EX bubble-insert and the IF/ID flush controls through a small FSM. It sits between the hazard detection logic and the pipeline registers, so the combinational hazard decisions become a clean registered stall/flush schedule.

---
 rtl/pipeline_stall_sequencer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/pipeline_stall_sequencer.sv
// pipeline_stall_sequencer
// Converts the hazard detector's combinational decisions into a registered
// stall/flush schedule for the MIPS front end (PC, IF/ID, ID/EX).
//
// Ports:
//   clk            pipeline clock, all state updates on rising edge
//   reset          synchronous active-high reset
//   data_hazard    data-hazard stall request for the instruction in IF
//   ctrl_req       branch/jump/jr decoded in ID (one-cycle pulse)
//   ctrl_count     extra wait cycles before resolution is usable
//   resolve_valid  control transfer resolved this cycle (pulse)
//   resolve_taken  qualifies resolve_valid, 1 = redirect taken
//   pc_en          PC register write enable
//   ifid_en        IF/ID register write enable
//   idex_bubble    force NOP into ID/EX
//   ifid_flush     clear IF/ID contents
//   state          current FSM state (RUN=0, DATA_STALL=1, CTRL_WAIT=2, FLUSH=3)
//   wd_timeout     sticky: data-stall watchdog fired since reset
//   stall_cycles   cycles with pc_en low (saturating), 0 unless STALL_STATS_EN
//   flush_count    FLUSH cycles seen (saturating), 0 unless STALL_STATS_EN
//
// Build option: define STALL_STATS_EN to instantiate the statistics counters.
module pipeline_stall_sequencer #(
  parameter int unsigned COUNT_W        = 32,
  parameter int unsigned MAX_DATA_STALL = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               data_hazard,
  input  logic               ctrl_req,
  input  logic [COUNT_W-1:0] ctrl_count,
  input  logic               resolve_valid,
  input  logic               resolve_taken,
  output logic               pc_en,
  output logic               ifid_en,
  output logic               idex_bubble,
  output logic               ifid_flush,
  output logic [1:0]         state,
  output logic               wd_timeout,
  output logic [31:0]        stall_cycles,
  output logic [31:0]        flush_count
);

  localparam int unsigned DsW = $clog2(MAX_DATA_STALL + 1);

  typedef enum logic [1:0] {
    StRun       = 2'd0,
    StDataStall = 2'd1,
    StCtrlWait  = 2'd2,
    StFlush     = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [COUNT_W-1:0] wait_q, wait_d;
  logic               pend_q, pend_d;
  logic               taken_q, taken_d;
  logic [DsW-1:0]     ds_q, ds_d;
  logic               wd_q, wd_d;
  logic               pc_en_q, pc_en_d;
  logic               ifid_en_q, ifid_en_d;
  logic               bubble_q, bubble_d;
  logic               flush_q, flush_d;
  logic               take_redirect;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    pend_d  = pend_q;
    taken_d = taken_q;
    ds_d    = ds_q;
    wd_d    = wd_q;
    // A live resolution overrides one latched while the wait counter ran.
    take_redirect = resolve_valid ? resolve_taken : taken_q;

    case (state_q)
      StRun: begin
        if (ctrl_req) begin
          state_d = StCtrlWait;
          wait_d  = ctrl_count;
          pend_d  = 1'b0;
          taken_d = 1'b0;
        end else if (data_hazard) begin
          state_d = StDataStall;
          ds_d    = DsW'(1);
        end
      end
      StDataStall: begin
        if (!data_hazard) begin
          state_d = StRun;
          ds_d    = '0;
        end else if (ds_q == DsW'(MAX_DATA_STALL)) begin
          state_d = StRun;
          wd_d    = 1'b1;
          ds_d    = '0;
        end else begin
          ds_d = ds_q + DsW'(1);
        end
      end
      StCtrlWait: begin
        if (wait_q != '0) begin
          wait_d = wait_q - COUNT_W'(1);
          if (resolve_valid) begin
            pend_d  = 1'b1;
            taken_d = resolve_taken;
          end
        end else if (resolve_valid || pend_q) begin
          state_d = take_redirect ? StFlush : StRun;
          pend_d  = 1'b0;
        end
      end
      StFlush: begin
        state_d = StRun;
        pend_d  = 1'b0;
      end
      default: state_d = StRun;
    endcase

    // Outputs are registered copies of the decode of the next state, so they
    // always equal the decode of state_q.
    pc_en_d   = (state_d == StRun) || (state_d == StFlush);
    ifid_en_d = (state_d == StRun) || (state_d == StFlush);
    bubble_d  = (state_d != StRun);
    flush_d   = (state_d == StFlush);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StRun;
      wait_q    <= '0;
      pend_q    <= 1'b0;
      taken_q   <= 1'b0;
      ds_q      <= '0;
      wd_q      <= 1'b0;
      pc_en_q   <= 1'b1;
      ifid_en_q <= 1'b1;
      bubble_q  <= 1'b0;
      flush_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      pend_q    <= pend_d;
      taken_q   <= taken_d;
      ds_q      <= ds_d;
      wd_q      <= wd_d;
      pc_en_q   <= pc_en_d;
      ifid_en_q <= ifid_en_d;
      bubble_q  <= bubble_d;
      flush_q   <= flush_d;
    end
  end

  assign pc_en       = pc_en_q;
  assign ifid_en     = ifid_en_q;
  assign idex_bubble = bubble_q;
  assign ifid_flush  = flush_q;
  assign state       = state_q;
  assign wd_timeout  = wd_q;

`ifdef STALL_STATS_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] flush_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (!pc_en_q && (stall_cycles_q != 32'hFFFF_FFFF)) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
      if ((state_q == StFlush) && (flush_count_q != 32'hFFFF_FFFF)) begin
        flush_count_q <= flush_count_q + 32'd1;
      end
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`else
  assign stall_cycles = 32'd0;
  assign flush_count  = 32'd0;
`endif

endmodule
